alu_unit: RTL
=============

ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL provide parameter ROB_WIDTH, default 4, width of the ROB tag carried with each operation.
REQ-002 SHALL provide parameter XLEN, default 32, operand and result width.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 2, input queue entries; power of two and at least 2.
REQ-004 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-low.
REQ-006 rdy_in  input  1  global enable; low means hold all state.
REQ-007 clear  input  1  pipeline flush (mispredict).
REQ-008 in_valid  input  1  issue request.
REQ-009 in_ready  output  1  unit can accept an issue this cycle.
REQ-010 in_a, in_b  input  XLEN  operands.
REQ-011 in_op  input  4  operation code.
REQ-012 in_tag  input  ROB_WIDTH  ROB tag.
REQ-013 out_valid  output  1  result register holds a completed operation.
REQ-014 out_ready  input  1  consumer (CDB) accepts the result.
REQ-015 out_result  output  XLEN  result.
REQ-016 out_tag  output  ROB_WIDTH  tag of out_result.

Function
REQ-017 Op codes SHALL be 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BGE, 12 BGEU, 13 BNE, 14 ADD_PC.
- All arithmetic is modulo 2^XLEN.
- Shifts use the low log2(XLEN) bits of b; SRA is sign-filling.
- SLT and BGE compare signed; SLTU and BGEU compare unsigned.
- Compare and branch ops return 1 or 0.
- ADD_PC returns a+b-4.
REQ-018 Issue transfer SHALL occur when in_valid, in_ready and rdy_in are all high and clear is low; the {a,b,op,tag} entry is pushed into the FIFO tail.
REQ-019 in_ready SHALL equal (FIFO count < FIFO_DEPTH) AND rdy_in; there is no push-through-when-full, even with a simultaneous pop.
REQ-020 Execute SHALL pop the FIFO head, compute its result, and load it into the output register in one edge whenever:
- the FIFO is non-empty, and
- the output register is empty or is being drained this cycle (out_valid and out_ready).
REQ-021 Minimum latency SHALL be 2 edges: accepted at edge N, out_valid high after edge N+1.
REQ-022 Back-to-back issue into an empty unit with out_ready held high SHALL sustain 1 result per cycle.
REQ-023 Results SHALL emerge in issue order.
REQ-024 While out_valid is high and out_ready is low, out_result and out_tag SHALL hold stable.
REQ-025 Simultaneous push and pop in one edge SHALL leave the count unchanged.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 When rdy_in is low, the FIFO, pointers and output register SHALL hold, and no issue or drain transfer occurs.
REQ-028 When clear and rdy_in are both high at an edge:
- the FIFO SHALL be emptied and out_valid forced to 0;
- any concurrent in_valid SHALL be discarded.
REQ-029 Op code 15 SHALL produce result 0 with its tag (unless REQ-033 applies).

Reset
REQ-030 When rst_in is low at an edge, the unit SHALL reset, with priority over clear and rdy_in:
- FIFO count and pointers 0;
- out_valid 0, out_result 0, out_tag 0.
REQ-031 in_ready SHALL be 0 while rst_in is low; a reset mid-operation discards all queued and held entries.

Configuration
REQ-032 Macro ALU_UNIT_MUL_EN SHALL select the op-15 behaviour.
REQ-033 With ALU_UNIT_MUL_EN defined, op 15 SHALL return the low XLEN bits of a*b, with the same single-edge execute timing.
REQ-034 Without ALU_UNIT_MUL_EN, op 15 SHALL behave per REQ-029 and no multiplier is synthesised.

Verification
REQ-035 Reset: rst_in low 2 cycles -> out_valid=0, in_ready=0; after release with rdy_in=1 -> in_ready=1.
REQ-036 Ops: issue SUB a=5 b=7 tag=3, SRA a=0x80000000 b=4, SLT a=0xFFFFFFFF b=1, ADD_PC a=0x100 b=8 -> results 0xFFFFFFFE (tag 3), 0xF8000000, 1, 0x104, each 2 edges after issue.
REQ-037 Backpressure: out_ready=0, issue 3 ops -> in_ready=0 after 2 queued + 1 held; out_result stable; raise out_ready -> 3 results in order on consecutive cycles.
REQ-038 Flush: 2 ops queued, 1 held, assert clear with in_valid=1 -> next cycle out_valid=0, FIFO empty, new op not accepted.
REQ-039 Stall: rdy_in=0 for 3 cycles mid-stream with in_valid=1, out_ready=1 -> no transfers and all state unchanged; resume -> stream continues without loss.
REQ-040 Op 15 a=6 b=7 -> 42 with ALU_UNIT_MUL_EN defined, 0 without it.

Source files
------------

// File: rtl/alu_unit.sv
// alu_unit: integer execution unit for the out-of-order core.
// Issued operations queue in a small FIFO; each cycle the head is
// executed and loaded into a single result register that feeds the CDB.
// Optional feature: define ALU_UNIT_MUL_EN to make op 15 a low-half
// multiply; without it op 15 returns 0 and no multiplier is built.
module alu_unit #(
  parameter int ROB_WIDTH  = 4,
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_a,
  input  logic [XLEN-1:0]      in_b,
  input  logic [3:0]           in_op,
  input  logic [ROB_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_result,
  output logic [ROB_WIDTH-1:0] out_tag
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SH_W  = $clog2(XLEN);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SLL    = 4'd5;
  localparam logic [3:0] OP_SRL    = 4'd6;
  localparam logic [3:0] OP_SRA    = 4'd7;
  localparam logic [3:0] OP_SLT    = 4'd8;
  localparam logic [3:0] OP_SLTU   = 4'd9;
  localparam logic [3:0] OP_BEQ    = 4'd10;
  localparam logic [3:0] OP_BGE    = 4'd11;
  localparam logic [3:0] OP_BGEU   = 4'd12;
  localparam logic [3:0] OP_BNE    = 4'd13;
  localparam logic [3:0] OP_ADD_PC = 4'd14;
`ifdef ALU_UNIT_MUL_EN
  localparam logic [3:0] OP_MUL    = 4'd15;
`endif

  logic [XLEN-1:0]      fifo_a   [FIFO_DEPTH];
  logic [XLEN-1:0]      fifo_b   [FIFO_DEPTH];
  logic [3:0]           fifo_op  [FIFO_DEPTH];
  logic [ROB_WIDTH-1:0] fifo_tag [FIFO_DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic            push;
  logic            pop;
  logic            drain;
  logic [XLEN-1:0] head_a;
  logic [XLEN-1:0] head_b;
  logic [3:0]      head_op;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] exec_result;

  // Handshake decisions: a full FIFO refuses issue even if it pops this cycle.
  always_comb begin
    in_ready = rst_in && rdy_in && (count < CNT_W'(FIFO_DEPTH));
    push     = in_valid && in_ready && !clear;
    drain    = out_valid && out_ready;
    pop      = rst_in && rdy_in && !clear && (count != '0) && (!out_valid || out_ready);
  end

  // Execute the FIFO head combinationally so it loads in a single edge.
  always_comb begin
    head_a      = fifo_a[head];
    head_b      = fifo_b[head];
    head_op     = fifo_op[head];
    shamt       = head_b[SH_W-1:0];
    exec_result = '0;
    case (head_op)
      OP_ADD:    exec_result = head_a + head_b;
      OP_SUB:    exec_result = head_a - head_b;
      OP_AND:    exec_result = head_a & head_b;
      OP_OR:     exec_result = head_a | head_b;
      OP_XOR:    exec_result = head_a ^ head_b;
      OP_SLL:    exec_result = head_a << shamt;
      OP_SRL:    exec_result = head_a >> shamt;
      OP_SRA:    exec_result = $unsigned($signed(head_a) >>> shamt);
      OP_SLT:    exec_result = XLEN'($signed(head_a) < $signed(head_b));
      OP_SLTU:   exec_result = XLEN'(head_a < head_b);
      OP_BEQ:    exec_result = XLEN'(head_a == head_b);
      OP_BGE:    exec_result = XLEN'($signed(head_a) >= $signed(head_b));
      OP_BGEU:   exec_result = XLEN'(head_a >= head_b);
      OP_BNE:    exec_result = XLEN'(head_a != head_b);
      OP_ADD_PC: exec_result = head_a + head_b - XLEN'(4);
`ifdef ALU_UNIT_MUL_EN
      OP_MUL:    exec_result = head_a * head_b;
`endif
      default:   exec_result = '0;
    endcase
  end

  // FIFO storage: written only on an accepted issue, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_a[tail]   <= in_a;
      fifo_b[tail]   <= in_b;
      fifo_op[tail]  <= in_op;
      fifo_tag[tail] <= in_tag;
    end
  end

  // Queue bookkeeping and result register, with reset > stall > flush.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        out_valid <= 1'b0;
      end else begin
        if (push) begin
          tail <= tail + PTR_W'(1);
        end
        if (pop) begin
          head <= head + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
        if (pop) begin
          out_valid  <= 1'b1;
          out_result <= exec_result;
          out_tag    <= fifo_tag[head];
        end else if (drain) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
